// File: rtl/conware_pump_pkg.sv
// Shared types and constants for the Conway life stream pump.
// The state encoding and default pixel colours live here so the pump and decoder agree on them.
package conware_pump_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] DEF_ALIVE_COLOR = 32'hFFFF_FFFF;
  localparam logic [31:0] DEF_DEAD_COLOR  = 32'h0000_0000;

  // Index width for a board of a given size; a one-cell board still needs one bit.
  function automatic int idx_width(input int cells);
    return (cells > 1) ? $clog2(cells) : 1;
  endfunction

endpackage

// File: rtl/conware_pump_frame_decoder.sv
// Receive side of the pump: counts incoming pixels, decodes them into the next board
// and flags framing and bad-pixel errors as single-cycle pulses.
module frame_decoder
  import conware_pump_pkg::*;
#(
  parameter int                DWIDTH      = 32,
  parameter int                WIDTH       = 8,
  parameter logic [DWIDTH-1:0] ALIVE_COLOR = DEF_ALIVE_COLOR,
  parameter logic [DWIDTH-1:0] DEAD_COLOR  = DEF_DEAD_COLOR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              active,
  input  logic              valid,
  input  logic [DWIDTH-1:0] data,
  input  logic              last,
  output logic              frame_end,
  output logic [WIDTH-1:0]  next_board,
  output logic              framing_err,
  output logic              pixel_err
);

  localparam int               IDX_W    = idx_width(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] acc;
  logic             accept;
  logic             at_last;
  logic             alive;

  assign accept  = active && valid;
  assign at_last = (idx == LAST_IDX);
  assign alive   = (data == ALIVE_COLOR);

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_board      = acc;
    next_board[idx] = alive;
    frame_end       = accept && (last || at_last);
    framing_err     = accept && (last ? !at_last : at_last);
    pixel_err       = accept && !alive && (data != DEAD_COLOR);
  end

  // NOTE: acc is cleared on reset and at every frame end because cells above the
  // current index rely on being zero; that is what kills them on an early TLAST.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= '0;
      acc <= '0;
    end else if (frame_end) begin
      idx <= '0;
      acc <= '0;
    end else if (accept) begin
      idx <= idx + IDX_W'(1);
      acc <= next_board;
    end
  end

endmodule

// File: rtl/conware_pump.sv
// Streams the current life board out as pixels, takes the next generation back in,
// and repeats for a requested number of generations.
module conware_pump
  import conware_pump_pkg::*;
#(
  parameter int                DWIDTH      = 32,
  parameter int                WIDTH       = 8,
  parameter logic [DWIDTH-1:0] ALIVE_COLOR = DEF_ALIVE_COLOR,
  parameter logic [DWIDTH-1:0] DEAD_COLOR  = DEF_DEAD_COLOR
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic [WIDTH-1:0]  seed,
  input  logic              seed_load,
  input  logic              start,
  input  logic [15:0]       num_gens,
  output logic              M_AXIS_TVALID,
  input  logic              M_AXIS_TREADY,
  output logic [DWIDTH-1:0] M_AXIS_TDATA,
  output logic              M_AXIS_TLAST,
  input  logic              S_AXIS_TVALID,
  output logic              S_AXIS_TREADY,
  input  logic [DWIDTH-1:0] S_AXIS_TDATA,
  input  logic              S_AXIS_TLAST,
  input  logic [3:0]        S_AXIS_TKEEP,
  input  logic [3:0]        S_AXIS_TSTRB,
  output logic [WIDTH-1:0]  board,
  output logic [15:0]       gen_count,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err
);

  localparam int               IDX_W    = idx_width(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] send_idx;
  logic [15:0]      gens_target;
  logic             send_hs;
  logic             ctrl_open;
  logic             frame_end;
  logic             framing_err;
  logic             pixel_err;
  logic [WIDTH-1:0] next_board;
  logic             unused_sideband;

  // Byte qualifiers carry no meaning for whole-pixel words.
  assign unused_sideband = ^{S_AXIS_TKEEP, S_AXIS_TSTRB};

  assign ctrl_open     = (state == IDLE) || (state == DONE);
  assign M_AXIS_TVALID = (state == SEND);
  assign M_AXIS_TLAST  = (state == SEND) && (send_idx == LAST_IDX);
  assign M_AXIS_TDATA  = (state != SEND) ? '0 : (board[send_idx] ? ALIVE_COLOR : DEAD_COLOR);
  assign S_AXIS_TREADY = (state == RECV);
  assign send_hs       = M_AXIS_TVALID && M_AXIS_TREADY;
  assign busy          = (state == SEND) || (state == RECV);
  assign done          = (state == DONE);

  frame_decoder #(
    .DWIDTH      (DWIDTH),
    .WIDTH       (WIDTH),
    .ALIVE_COLOR (ALIVE_COLOR),
    .DEAD_COLOR  (DEAD_COLOR)
  ) u_decoder (
    .clk         (ACLK),
    .rst_n       (ARESETN),
    .active      (S_AXIS_TREADY),
    .valid       (S_AXIS_TVALID),
    .data        (S_AXIS_TDATA),
    .last        (S_AXIS_TLAST),
    .frame_end   (frame_end),
    .next_board  (next_board),
    .framing_err (framing_err),
    .pixel_err   (pixel_err)
  );

  // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_next;
  end

  // A seed_load drops back to IDLE so done clears; start with zero generations finishes at once.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (seed_load)  state_next = IDLE;
        else if (start) state_next = (num_gens != 16'd0) ? SEND : DONE;
      end
      SEND: if (send_hs && send_idx == LAST_IDX) state_next = RECV;
      RECV: if (frame_end) state_next = (gen_count + 16'd1 < gens_target) ? SEND : DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      board       <= '0;
      gen_count   <= '0;
      err         <= '0;
      gens_target <= '0;
      send_idx    <= '0;
    end else begin
      if (ctrl_open && seed_load) begin
        board     <= seed;
        gen_count <= '0;
        err       <= '0;
      end else if (ctrl_open && start) begin
        gens_target <= num_gens;
        gen_count   <= '0;
        err         <= '0;
        send_idx    <= '0;
      end
      if (send_hs) send_idx <= (send_idx == LAST_IDX) ? '0 : send_idx + IDX_W'(1);
      if (state == RECV) begin
        err <= err | {pixel_err, framing_err};
        if (frame_end) begin
          board     <= next_board;
          gen_count <= gen_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conware_pump.sv
// Directed bench for conware_pump: a scripted responder plays the life engine
// and each scenario task checks the stream and status against hand-computed values.
module tb_conware_pump;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [7:0]  seed = '0;
  logic        seed_load = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_gens = '0;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY = 1'b0;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TLAST;
  logic        S_AXIS_TVALID = 1'b0;
  logic        S_AXIS_TREADY;
  logic [31:0] S_AXIS_TDATA = '0;
  logic        S_AXIS_TLAST = 1'b0;
  logic [7:0]  board;
  logic [15:0] gen_count;
  logic        busy;
  logic        done;
  logic [1:0]  err;

  int checks = 0;
  int errors = 0;
  logic [7:0][31:0] cap;

  localparam logic [31:0] A = 32'hFFFF_FFFF;
  localparam logic [31:0] D = 32'h0000_0000;

  conware_pump dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .seed          (seed),
    .seed_load     (seed_load),
    .start         (start),
    .num_gens      (num_gens),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .S_AXIS_TKEEP  (4'hF),
    .S_AXIS_TSTRB  (4'hF),
    .board         (board),
    .gen_count     (gen_count),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running");
    $fatal(1);
  end

  function automatic logic [7:0][31:0] frame_of(input logic [7:0] b);
    logic [7:0][31:0] f;
    for (int i = 0; i < 8; i++) f[i] = b[i] ? A : D;
    return f;
  endfunction

  task automatic do_seed(input logic [7:0] s);
    @(negedge ACLK); seed = s; seed_load = 1'b1;
    @(negedge ACLK); seed_load = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] n);
    @(negedge ACLK); num_gens = n; start = 1'b1;
    @(negedge ACLK); start = 1'b0;
  endtask

  // Consumes one outgoing frame, checking each word against the expected board and
  // that a stalled word holds its data and TLAST.
  task automatic send_phase(input string name, input logic [7:0] exp_b, input bit stalls);
    int k = 0;
    int cyc = 0;
    logic held = 1'b0;
    logic [31:0] hd = '0;
    logic hl = 1'b0;
    while (k < 8 && cyc < 200) begin
      @(negedge ACLK); cyc++;
      if (held) begin
        checks++;
        if (M_AXIS_TVALID !== 1'b1 || M_AXIS_TDATA !== hd || M_AXIS_TLAST !== hl) begin
          errors++;
          $display("FAIL %s hold: got v=%b d=%h l=%b, need v=1 d=%h l=%b", name, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST, hd, hl);
        end
      end
      M_AXIS_TREADY = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        checks++;
        if (M_AXIS_TDATA !== (exp_b[k] ? A : D) || M_AXIS_TLAST !== (k == 7)) begin
          errors++;
          $display("FAIL %s word%0d: got %h last=%b, need %h last=%b", name, k, M_AXIS_TDATA, M_AXIS_TLAST, exp_b[k] ? A : D, k == 7);
        end
        cap[k] = M_AXIS_TDATA;
        k++;
        held = 1'b0;
      end else begin
        held = M_AXIS_TVALID; hd = M_AXIS_TDATA; hl = M_AXIS_TLAST;
      end
    end
    checks++;
    if (k != 8 || (!stalls && cyc != 8)) begin
      errors++;
      $display("FAIL %s send_count: got %0d words in %0d cycles, need 8", name, k, cyc);
    end
    @(negedge ACLK); M_AXIS_TREADY = 1'b0;
    checks++;
    if (S_AXIS_TREADY !== 1'b1 || M_AXIS_TVALID !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s enter_recv: got s_ready=%b m_valid=%b busy=%b, need 1 0 1", name, S_AXIS_TREADY, M_AXIS_TVALID, busy);
    end
  endtask

  // Returns n words to the pump; board must not move until the frame ends.
  task automatic recv_phase(input string name, input logic [7:0][31:0] w, input logic [7:0] lasts,
                            input int n, input bit stalls, input logic [7:0] b_before);
    int k = 0;
    int cyc = 0;
    bit moved = 1'b0;
    while (k < n && cyc < 200) begin
      @(negedge ACLK); cyc++;
      if (board !== b_before) moved = 1'b1;
      if (stalls && $urandom_range(0, 2) == 0) begin
        S_AXIS_TVALID = 1'b0;
      end else begin
        S_AXIS_TVALID = 1'b1; S_AXIS_TDATA = w[k]; S_AXIS_TLAST = lasts[k];
      end
      if (S_AXIS_TVALID && S_AXIS_TREADY) k++;
    end
    checks++;
    if (k != n || moved) begin
      errors++;
      $display("FAIL %s recv: got %0d words moved=%b, need %0d words moved=0", name, k, moved, n);
    end
    @(negedge ACLK); S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0;
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    checks++;
    if ({board, gen_count, err, done, busy, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, S_AXIS_TREADY} !== '0) begin
      errors++;
      $display("FAIL reset: got board=%h gen=%0d err=%b done=%b busy=%b mv=%b ml=%b md=%h sr=%b, need all 0",
               board, gen_count, err, done, busy, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, S_AXIS_TREADY);
    end
    ARESETN = 1'b1;
  endtask

  task automatic test_loopback();
    do_seed(8'b1010_0101);
    checks++;
    if (board !== 8'hA5 || busy !== 1'b0) begin
      errors++; $display("FAIL seed_load: got board=%h busy=%b, need a5 0", board, busy);
    end
    do_start(16'd1);
    checks++;
    if (M_AXIS_TVALID !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL start_valid: got v=%b busy=%b done=%b, need 1 1 0", M_AXIS_TVALID, busy, done);
    end
    send_phase("loopback", 8'hA5, 1'b0);
    recv_phase("loopback", cap, 8'h80, 8, 1'b0, 8'hA5);
    checks++;
    if (board !== 8'hA5 || gen_count !== 16'd1 || done !== 1'b1 || err !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL loopback_end: got board=%h gen=%0d done=%b err=%b busy=%b, need a5 1 1 00 0", board, gen_count, done, err, busy);
    end
  endtask

  task automatic test_priority();
    @(negedge ACLK); seed = 8'h5A; seed_load = 1'b1; start = 1'b1; num_gens = 16'd1;
    @(negedge ACLK); seed_load = 1'b0; start = 1'b0;
    checks++;
    if (board !== 8'h5A || busy !== 1'b0 || done !== 1'b0 || M_AXIS_TVALID !== 1'b0 || gen_count !== 16'd0) begin
      errors++;
      $display("FAIL priority: got board=%h busy=%b done=%b mv=%b gen=%0d, need 5a 0 0 0 0", board, busy, done, M_AXIS_TVALID, gen_count);
    end
  endtask

  task automatic test_multi_gen();
    do_seed(8'h3C);
    do_start(16'd3);
    for (int g = 0; g < 3; g++) begin
      send_phase("multi", (g == 0) ? 8'h3C : 8'hF0, 1'b0);
      recv_phase("multi", frame_of(8'hF0), 8'h80, 8, 1'b0, (g == 0) ? 8'h3C : 8'hF0);
      checks++;
      if (gen_count !== 16'(g + 1) || board !== 8'hF0 || done !== (g == 2) || busy !== (g < 2)) begin
        errors++;
        $display("FAIL multi_gen%0d: got gen=%0d board=%h done=%b busy=%b, need %0d f0 %b %b",
                 g, gen_count, board, done, busy, g + 1, g == 2, g < 2);
      end
    end
  endtask

  task automatic test_stalls();
    do_seed(8'h96);
    do_start(16'd2);
    send_phase("stall1", 8'h96, 1'b1);
    recv_phase("stall1", frame_of(8'h69), 8'h80, 8, 1'b1, 8'h96);
    checks++;
    if (board !== 8'h69 || gen_count !== 16'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL stall_gen1: got board=%h gen=%0d busy=%b, need 69 1 1", board, gen_count, busy);
    end
    send_phase("stall2", 8'h69, 1'b1);
    recv_phase("stall2", frame_of(8'h96), 8'h80, 8, 1'b1, 8'h69);
    checks++;
    if (board !== 8'h96 || gen_count !== 16'd2 || done !== 1'b1 || err !== 2'b00) begin
      errors++; $display("FAIL stall_end: got board=%h gen=%0d done=%b err=%b, need 96 2 1 00", board, gen_count, done, err);
    end
  endtask

  task automatic test_early_last();
    do_seed(8'h00);
    do_start(16'd1);
    send_phase("early", 8'h00, 1'b0);
    recv_phase("early", frame_of(8'hFF), 8'h10, 5, 1'b0, 8'h00);
    checks++;
    if (board !== 8'h1F || err !== 2'b01 || gen_count !== 16'd1 || done !== 1'b1) begin
      errors++; $display("FAIL early_last: got board=%h err=%b gen=%0d done=%b, need 1f 01 1 1", board, err, gen_count, done);
    end
  endtask

  task automatic test_bad_pixel();
    logic [7:0][31:0] f;
    do_seed(8'h00);
    do_start(16'd2);
    f = frame_of(8'hFF);
    f[2] = 32'h1234_5678;
    send_phase("badpix", 8'h00, 1'b0);
    recv_phase("badpix", f, 8'h80, 8, 1'b0, 8'h00);
    checks++;
    if (board !== 8'hFB || err !== 2'b10 || gen_count !== 16'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL bad_pixel: got board=%h err=%b gen=%0d busy=%b, need fb 10 1 1", board, err, gen_count, busy);
    end
    send_phase("badpix2", 8'hFB, 1'b0);
    recv_phase("nolast", frame_of(8'hFF), 8'h00, 8, 1'b0, 8'hFB);
    checks++;
    if (board !== 8'hFF || err !== 2'b11 || gen_count !== 16'd2 || done !== 1'b1) begin
      errors++; $display("FAIL missing_last: got board=%h err=%b gen=%0d done=%b, need ff 11 2 1", board, err, gen_count, done);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_valid = 1'b0;
    do_seed(8'hFF);
    do_start(16'd1);
    send_phase("rstmid", 8'hFF, 1'b0);
    recv_phase("rstmid", frame_of(8'hFF), 8'h00, 3, 1'b0, 8'hFF);
    S_AXIS_TVALID = 1'b1; S_AXIS_TDATA = A; S_AXIS_TLAST = 1'b0; ARESETN = 1'b0;
    @(negedge ACLK);
    checks++;
    if ({board, gen_count, err, done, busy, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, S_AXIS_TREADY} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got board=%h gen=%0d err=%b done=%b busy=%b mv=%b ml=%b md=%h sr=%b, need all 0",
               board, gen_count, err, done, busy, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, S_AXIS_TREADY);
    end
    ARESETN = 1'b1; S_AXIS_TVALID = 1'b0;
    do_start(16'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || M_AXIS_TVALID !== 1'b0 || gen_count !== 16'd0) begin
      errors++; $display("FAIL zero_gens: got done=%b busy=%b mv=%b gen=%0d, need 1 0 0 0", done, busy, M_AXIS_TVALID, gen_count);
    end
    repeat (4) begin
      @(negedge ACLK);
      if (M_AXIS_TVALID !== 1'b0) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid || done !== 1'b1) begin
      errors++; $display("FAIL zero_gens_quiet: got saw_valid=%b done=%b, need 0 1", saw_valid, done);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_priority();
    test_multi_gen();
    test_stalls();
    test_early_last();
    test_bad_pixel();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
